// File: rtl/stepper_seq.sv
// Four-coil stepper sequencer: runs a latched move command through the half-step
// coil table at a programmable rate and tracks signed absolute position.
module stepper_seq #(
  parameter int COUNT_W = 16,
  parameter int DIV_W   = 16,
  parameter int POS_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] steps,
  input  logic [DIV_W-1:0]   period,
  input  logic               hold,
  output logic [3:0]         motorControl,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] remaining,
  output logic [POS_W-1:0]   position
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [2:0]         idx_r, idx_s;
  logic [POS_W-1:0]   pos_r, pos_s;
  logic [COUNT_W-1:0] rem_r, rem_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [DIV_W-1:0]   last_r, last_s;
  logic               dir_r, dir_s;
  logic               half_r, half_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               abort_r, abort_s;
  logic [3:0]         coil_r, coil_s;
  logic               step_s;
  logic [2:0]         idx_inc_s;
  logic [POS_W-1:0]   pos_inc_s;
  logic [2:0]         idx_adv_s;
  logic [POS_W-1:0]   pos_adv_s;

  function automatic logic [3:0] coil_pattern(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      3'd7:    p = 4'b1001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  // Next-state, step datapath and coil output decode
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    pos_s   = pos_r;
    rem_s   = rem_r;
    div_s   = div_r;
    last_s  = last_r;
    dir_s   = dir_r;
    half_s  = half_r;
    done_s  = 1'b0;
    abort_s = abort_r;

    // last_r holds P-1, so a step fires when the divider reaches it
    step_s    = (div_r == last_r);
    idx_inc_s = half_r ? 3'd1 : 3'd2;
    pos_inc_s = {{(POS_W-2){1'b0}}, (half_r ? 2'b01 : 2'b10)};
    idx_adv_s = dir_r ? (idx_r + idx_inc_s) : (idx_r - idx_inc_s);
    pos_adv_s = dir_r ? (pos_r + pos_inc_s) : (pos_r - pos_inc_s);

    case (state_r)
      IDLE: begin
        if (start) begin
          if (steps != {COUNT_W{1'b0}}) begin
            state_s = RUN;
            dir_s   = dir;
            half_s  = mode[1];
            rem_s   = steps;
            div_s   = {DIV_W{1'b0}};
            last_s  = (period == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (period - {{(DIV_W-1){1'b0}}, 1'b1});
            abort_s = 1'b0;
            case (mode)
              2'b00:   idx_s = {idx_r[2:1], 1'b0};
              2'b01:   idx_s = {idx_r[2:1], 1'b1};
              default: idx_s = idx_r;
            endcase
          end else begin
            done_s  = 1'b1;
            abort_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (step_s && (rem_r == {{(COUNT_W-1){1'b0}}, 1'b1})) begin
          // Final step wins over a simultaneous stop
          idx_s   = idx_adv_s;
          pos_s   = pos_adv_s;
          rem_s   = {COUNT_W{1'b0}};
          div_s   = {DIV_W{1'b0}};
          state_s = IDLE;
          done_s  = 1'b1;
          abort_s = 1'b0;
        end else if (stop) begin
          state_s = IDLE;
          done_s  = 1'b1;
          abort_s = 1'b1;
        end else if (step_s) begin
          idx_s = idx_adv_s;
          pos_s = pos_adv_s;
          rem_s = rem_r - {{(COUNT_W-1){1'b0}}, 1'b1};
          div_s = {DIV_W{1'b0}};
        end else begin
          div_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == RUN);
    if (busy_s || hold) begin
      coil_s = coil_pattern(idx_s);
    end else begin
      coil_s = 4'b0000;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      pos_r   <= {POS_W{1'b0}};
      rem_r   <= {COUNT_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      last_r  <= {DIV_W{1'b0}};
      dir_r   <= 1'b0;
      half_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      coil_r  <= 4'b0000;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      pos_r   <= pos_s;
      rem_r   <= rem_s;
      div_r   <= div_s;
      last_r  <= last_s;
      dir_r   <= dir_s;
      half_r  <= half_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      abort_r <= abort_s;
      coil_r  <= coil_s;
    end
  end

  assign motorControl = coil_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign aborted      = abort_r;
  assign remaining    = rem_r;
  assign position     = pos_r;

endmodule
